// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and downstream memory signals of the unified memory port arbiter
// master: arbiter side (takes i_* requests/acks, drives o_* responses and downstream request)
// slave:  environment side (requesters plus downstream memory)
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32
);
  logic                   i_if_req;
  logic [ADDR_WIDTH-1:0]  i_if_addr;
  logic                   o_if_ready;
  logic [INSTR_WIDTH-1:0] o_if_rdata;
  logic                   o_if_err;
  logic                   i_dm_req;
  logic                   i_dm_we;
  logic [1:0]             i_dm_store_type;
  logic [ADDR_WIDTH-1:0]  i_dm_addr;
  logic [DATA_WIDTH-1:0]  i_dm_wdata;
  logic                   o_dm_ready;
  logic [DATA_WIDTH-1:0]  o_dm_rdata;
  logic                   o_dm_err;
  logic                   o_mem_req;
  logic                   o_mem_we;
  logic [1:0]             o_mem_store_type;
  logic [ADDR_WIDTH-1:0]  o_mem_addr;
  logic [DATA_WIDTH-1:0]  o_mem_wdata;
  logic                   i_mem_ack;
  logic [DATA_WIDTH-1:0]  i_mem_rdata;
  modport master (
    input  i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_store_type, i_dm_addr, i_dm_wdata, i_mem_ack, i_mem_rdata,
    output o_if_ready, o_if_rdata, o_if_err, o_dm_ready, o_dm_rdata, o_dm_err,
           o_mem_req, o_mem_we, o_mem_store_type, o_mem_addr, o_mem_wdata
  );
  modport slave (
    output i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_store_type, i_dm_addr, i_dm_wdata, i_mem_ack, i_mem_rdata,
    input  o_if_ready, o_if_rdata, o_if_err, o_dm_ready, o_dm_rdata, o_dm_err,
           o_mem_req, o_mem_we, o_mem_store_type, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, data first with a fetch starvation guard
// clk, arst: clock and asynchronous active-high reset
// bus (master): fetch and data request/response channels plus the downstream req/ack memory channel
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int INSTR_WIDTH     = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input logic clk,
  input logic arst,
  mem_port_arbiter_if.master bus
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HI = $clog2(INSTR_WIDTH / 8);
  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, RESP} state_t;
  state_t state, nxt;
  logic [SW-1:0] streak;
  logic [CW-1:0] cnt;
  logic gnt_d, we, err, busy, tmo, pick_d, resp_d, resp_i;
  logic [1:0] st;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  always_ff @(posedge clk or posedge arst)
    if (arst) state <= IDLE;
    else state <= nxt;
  // tmo flags the last allowed busy cycle, so o_mem_req stays up exactly TIMEOUT_CYCLES cycles
  always_comb begin
    busy = state == BUSY_D || state == BUSY_I;
    tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
    pick_d = bus.i_dm_req && (!bus.i_if_req || streak < SW'(MAX_DATA_STREAK));
    nxt = state == IDLE ? (pick_d ? BUSY_D : bus.i_if_req ? BUSY_I : IDLE)
        : busy ? (bus.i_mem_ack || tmo ? RESP : state)
        : IDLE;
  end
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      streak <= '0;
      cnt <= '0;
      gnt_d <= 1'b0;
      we <= 1'b0;
      st <= '0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      err <= 1'b0;
    end else begin
      cnt <= busy ? cnt + CW'(1) : '0;
      if (state == IDLE && pick_d) begin
        gnt_d <= 1'b1;
        we <= bus.i_dm_we;
        st <= bus.i_dm_store_type;
        addr <= bus.i_dm_addr;
        wdata <= bus.i_dm_wdata;
        streak <= streak == SW'(MAX_DATA_STREAK) ? streak : streak + SW'(1);
      end else if (state == IDLE && bus.i_if_req) begin
        gnt_d <= 1'b0;
        we <= 1'b0;
        st <= '0;
        addr <= bus.i_if_addr;
        wdata <= '0;
        streak <= '0;
      end
      // ack beats a simultaneous timeout
      if (busy && (bus.i_mem_ack || tmo)) begin
        rdata <= bus.i_mem_ack ? bus.i_mem_rdata : '0;
        err <= !bus.i_mem_ack;
      end
    end
  assign resp_d = state == RESP && gnt_d;
  assign resp_i = state == RESP && !gnt_d;
  assign bus.o_mem_req = busy;
  assign bus.o_mem_we = busy && we;
  assign bus.o_mem_store_type = busy ? st : '0;
  assign bus.o_mem_addr = busy ? addr : '0;
  assign bus.o_mem_wdata = busy ? wdata : '0;
  assign bus.o_if_ready = resp_i;
  assign bus.o_if_err = resp_i && err;
  assign bus.o_if_rdata = !resp_i ? '0 : addr[HI] ? rdata[INSTR_WIDTH +: INSTR_WIDTH] : rdata[INSTR_WIDTH-1:0];
  assign bus.o_dm_ready = resp_d;
  assign bus.o_dm_err = resp_d && err;
  assign bus.o_dm_rdata = resp_d && !we ? rdata : '0;
endmodule
